// File: rtl/gold_bag_motion_if.sv
// ---------------------------------------------------------------------------
// gold_bag_motion_if
//   Groups the frame-rate control inputs and the drawing/collision outputs of
//   one gold bag controller.
//
//   Frame protocol: there is no valid/ready pair on this block. startOfFrame
//   is a one-clock pulse that acts as an always-accepted "valid" for one frame
//   of motion. push_req may be raised on any clock and is held in a latch until
//   the next startOfFrame consumes it. All outputs are registered state and
//   hold steady between frames, except push_blocked, which is a one-clock pulse.
//
//   master : the environment (digger logic / testbench), drives the inputs
//   slave  : the gold_bag_motion controller
//
//   Signals
//     startOfFrame  frame strobe
//     respawn       synchronous level restart, overrides everything
//     push_req      digger is pushing the bag
//     push_side     0 = pusher on the left (bag moves right), 1 = on the right
//     can_fall      cell below the bag is empty
//     been_eaten    digger touches a crashed bag
//     topLeftX/Y    pixel position (signed, 11 bit)
//     gold_state    0 rest/push/wobble, 1 falling, 2 crashed, 3 collected
//     image         0 upright, 1 tilt left, 2 tilt right, 3 broken
//     push_blocked  one-clock pulse when a latched push is refused
//     busy          bag is moving or wobbling
//     dbg_state     raw controller state, for debug and checker binding
// ---------------------------------------------------------------------------
interface gold_bag_motion_if;
    logic               startOfFrame;
    logic               respawn;
    logic               push_req;
    logic               push_side;
    logic               can_fall;
    logic               been_eaten;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic [1:0]         gold_state;
    logic [1:0]         image;
    logic               push_blocked;
    logic               busy;
    logic [2:0]         dbg_state;

    modport master (
        output startOfFrame, respawn, push_req, push_side, can_fall, been_eaten,
        input  topLeftX, topLeftY, gold_state, image, push_blocked, busy, dbg_state
    );

    modport slave (
        input  startOfFrame, respawn, push_req, push_side, can_fall, been_eaten,
        output topLeftX, topLeftY, gold_state, image, push_blocked, busy, dbg_state
    );
endinterface

// File: rtl/gold_bag_motion.sv
// ---------------------------------------------------------------------------
// gold_bag_motion
//   Movement controller for one gold bag: side pushes, wobble before a fall,
//   accelerating fall snapped to cell boundaries, crash classification by
//   cells fallen, collection and respawn. Positions are fixed point
//   (pixels * 2^FRAC_BITS) in 32-bit signed registers.
//
//   Ports
//     clk     system clock
//     resetN  asynchronous active-low reset
//     bus     gold_bag_motion_if.slave (frame strobe, push/fall inputs,
//             position / status / image outputs, debug state)
// ---------------------------------------------------------------------------
module gold_bag_motion #(
    parameter int INITIAL_X          = 32,
    parameter int INITIAL_Y          = 160,
    parameter int CELL_BITS          = 5,
    parameter int FRAC_BITS          = 6,
    parameter int X_SPEED            = 128,
    parameter int Y_SPEED_INIT       = 128,
    parameter int Y_ACCEL            = 16,
    parameter int MAX_Y_SPEED        = 512,
    parameter int WOBBLE_FRAMES      = 90,
    parameter int WOBBLE_PERIOD_BITS = 4,
    parameter int CRASH_CELLS        = 2,
    parameter int MIN_X              = 0,
    parameter int MAX_X              = 608
) (
    input  logic             clk,
    input  logic             resetN,
    gold_bag_motion_if.slave bus
);

    localparam int                 CF       = CELL_BITS + FRAC_BITS;
    localparam logic signed [31:0] CELL_FP  = 32'sd1 <<< CF;
    localparam logic signed [31:0] X0       = 32'(INITIAL_X) <<< FRAC_BITS;
    localparam logic signed [31:0] Y0       = 32'(INITIAL_Y) <<< FRAC_BITS;
    localparam logic signed [31:0] XSPD     = 32'(X_SPEED);
    localparam logic signed [31:0] YSPD0    = 32'(Y_SPEED_INIT);
    localparam logic signed [31:0] YACC     = 32'(Y_ACCEL);
    localparam logic signed [31:0] YMAX     = 32'(MAX_Y_SPEED);
    localparam logic signed [31:0] XMIN_PX  = 32'(MIN_X);
    localparam logic signed [31:0] XMAX_PX  = 32'(MAX_X);
    localparam logic [15:0]        WOB_LAST = 16'(WOBBLE_FRAMES - 1);
    localparam logic [4:0]         CRASH_N  = 5'(CRASH_CELLS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PUSH_R    = 3'd1,
        S_PUSH_L    = 3'd2,
        S_WOBBLE    = 3'd3,
        S_FALLING   = 3'd4,
        S_CRASHED   = 3'd5,
        S_COLLECTED = 3'd6
    } state_t;

    state_t             state_q, state_n;
    logic signed [31:0] x_q, x_n;
    logic signed [31:0] y_q, y_n;
    logic signed [31:0] spd_q, spd_n;
    logic [15:0]        wob_q, wob_n;
    logic [3:0]         cells_q, cells_n;
    logic               latch_q, latch_n;
    logic               side_q, side_n;
    logic               blk_q, blk_n;

    // Move toward +inf by spd, never passing the next cell boundary above old.
    function automatic logic signed [31:0] step_up(input logic signed [31:0] old,
                                                   input logic signed [31:0] spd);
        logic signed [31:0] nb;
        logic signed [31:0] sum;
        nb  = ((old >>> CF) <<< CF) + CELL_FP;
        sum = old + spd;
        return (sum > nb) ? nb : sum;
    endfunction

    // Move toward -inf by spd, never passing the next cell boundary below old.
    // Starting exactly on a boundary, the limit is the one a full cell lower.
    function automatic logic signed [31:0] step_down(input logic signed [31:0] old,
                                                     input logic signed [31:0] spd);
        logic signed [31:0] fl;
        logic signed [31:0] pb;
        logic signed [31:0] dif;
        fl  = (old >>> CF) <<< CF;
        pb  = (fl == old) ? (old - CELL_FP) : fl;
        dif = old - spd;
        return (dif < pb) ? pb : dif;
    endfunction

    function automatic logic aligned(input logic signed [31:0] v);
        return v[CF-1:FRAC_BITS] == '0;
    endfunction

    // Register process: everything moves only through the *_n values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            x_q     <= X0;
            y_q     <= Y0;
            spd_q   <= YSPD0;
            wob_q   <= '0;
            cells_q <= '0;
            latch_q <= 1'b0;
            side_q  <= 1'b0;
            blk_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            spd_q   <= spd_n;
            wob_q   <= wob_n;
            cells_q <= cells_n;
            latch_q <= latch_n;
            side_q  <= side_n;
            blk_q   <= blk_n;
        end
    end

    logic               push_now;
    logic               side_now;
    logic signed [31:0] px_x;
    logic signed [31:0] step;
    logic signed [31:0] spd_sum;
    logic [3:0]         cells_inc;

    always_comb begin
        state_n   = state_q;
        x_n       = x_q;
        y_n       = y_q;
        spd_n     = spd_q;
        wob_n     = wob_q;
        cells_n   = cells_q;
        latch_n   = latch_q;
        side_n    = side_q;
        blk_n     = 1'b0;
        // A request on the frame clock itself counts for that frame.
        push_now  = latch_q | bus.push_req;
        side_now  = bus.push_req ? bus.push_side : side_q;
        px_x      = x_q >>> FRAC_BITS;
        step      = '0;
        spd_sum   = spd_q + YACC;
        cells_inc = (cells_q == 4'hF) ? cells_q : cells_q + 4'd1;

        if (bus.respawn) begin
            state_n = S_IDLE;
            x_n     = X0;
            y_n     = Y0;
            spd_n   = YSPD0;
            wob_n   = '0;
            cells_n = '0;
            latch_n = 1'b0;
            side_n  = 1'b0;
        end else if (bus.startOfFrame) begin
            latch_n = 1'b0;
            side_n  = side_now;
            case (state_q)
                S_IDLE: begin
                    if (push_now) begin
                        if (!side_now) begin
                            if (px_x >= XMAX_PX) begin
                                blk_n = 1'b1;
                            end else begin
                                step    = step_up(x_q, XSPD);
                                x_n     = step;
                                state_n = aligned(step) ? S_IDLE : S_PUSH_R;
                            end
                        end else begin
                            if (px_x <= XMIN_PX) begin
                                blk_n = 1'b1;
                            end else begin
                                step    = step_down(x_q, XSPD);
                                x_n     = step;
                                state_n = aligned(step) ? S_IDLE : S_PUSH_L;
                            end
                        end
                    end else if (bus.can_fall) begin
                        state_n = S_WOBBLE;
                        wob_n   = '0;
                    end
                end
                S_PUSH_R: begin
                    step = step_up(x_q, XSPD);
                    x_n  = step;
                    if (aligned(step)) state_n = S_IDLE;
                end
                S_PUSH_L: begin
                    step = step_down(x_q, XSPD);
                    x_n  = step;
                    if (aligned(step)) state_n = S_IDLE;
                end
                S_WOBBLE: begin
                    if (!bus.can_fall) begin
                        state_n = S_IDLE;
                    end else begin
                        wob_n = wob_q + 16'd1;
                        // The frame that reaches the last count only switches
                        // to falling; the first Y move happens next frame.
                        if (wob_q + 16'd1 == WOB_LAST) begin
                            state_n = S_FALLING;
                            spd_n   = YSPD0;
                            cells_n = '0;
                        end
                    end
                end
                S_FALLING: begin
                    step  = step_up(y_q, spd_q);
                    y_n   = step;
                    spd_n = (spd_sum > YMAX) ? YMAX : spd_sum;
                    if (aligned(step)) begin
                        cells_n = cells_inc;
                        if (!bus.can_fall) begin
                            state_n = ({1'b0, cells_inc} >= CRASH_N) ? S_CRASHED : S_IDLE;
                        end
                    end
                end
                S_CRASHED: begin
                    if (bus.been_eaten) state_n = S_COLLECTED;
                end
                default: begin
                end
            endcase
        end else if (bus.push_req) begin
            latch_n = 1'b1;
            side_n  = bus.push_side;
        end
    end

    logic [1:0] img;
    logic [1:0] phase;

    always_comb begin
        img   = 2'd0;
        phase = wob_q[WOBBLE_PERIOD_BITS+1:WOBBLE_PERIOD_BITS];
        case (state_q)
            S_WOBBLE: begin
                case (phase)
                    2'd1:    img = 2'd1;
                    2'd3:    img = 2'd2;
                    default: img = 2'd0;
                endcase
            end
            S_CRASHED: img = 2'd3;
            default:   img = 2'd0;
        endcase
    end

    always_comb begin
        case (state_q)
            S_FALLING:   bus.gold_state = 2'd1;
            S_CRASHED:   bus.gold_state = 2'd2;
            S_COLLECTED: bus.gold_state = 2'd3;
            default:     bus.gold_state = 2'd0;
        endcase
    end

    assign bus.topLeftX     = x_q[FRAC_BITS+10:FRAC_BITS];
    assign bus.topLeftY     = y_q[FRAC_BITS+10:FRAC_BITS];
    assign bus.image        = img;
    assign bus.push_blocked = blk_q;
    assign bus.busy         = (state_q != S_IDLE) && (state_q != S_CRASHED) &&
                              (state_q != S_COLLECTED);
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_gold_bag_motion.sv
// ---------------------------------------------------------------------------
// tb_gold_bag_motion
//   Directed scenarios followed by randomized frames. A behavioural model
//   of the bag (plain integer arithmetic on fixed-point positions) predicts
//   every output after every clock; predictions go through exp_q and are
//   compared by chk(). MIN_X is raised to 32 so a left push at spawn is
//   refused.
// ---------------------------------------------------------------------------
module tb_gold_bag_motion;

    localparam int FRAC    = 64;           // 2^FRAC_BITS
    localparam int CELLPX  = 32;
    localparam int CELL_FP = CELLPX * FRAC;
    localparam int INIT_X  = 32;
    localparam int INIT_Y  = 160;
    localparam int XSPD    = 128;
    localparam int YSPD0   = 128;
    localparam int YACC    = 16;
    localparam int YMAX    = 512;
    localparam int WOBN    = 90;
    localparam int CRASHN  = 2;
    localparam int MINX    = 32;
    localparam int MAXX    = 608;

    localparam int M_REST = 0, M_RIGHT = 1, M_LEFT = 2, M_WOB = 3,
                   M_FALL = 4, M_CRASH = 5, M_GONE = 6;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    gold_bag_motion_if bus();

    gold_bag_motion #(.MIN_X(MINX)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    logic [27:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_x, m_y, m_spd, m_wob, m_cells, m_mode;
    bit m_latch, m_side, m_blk;

    function automatic int m_up(int v, int s);
        int nb = (v / CELL_FP + 1) * CELL_FP;
        return (v + s > nb) ? nb : v + s;
    endfunction

    function automatic int m_down(int v, int s);
        int fl = (v / CELL_FP) * CELL_FP;
        int pb = (fl == v) ? v - CELL_FP : fl;
        return (v - s < pb) ? pb : v - s;
    endfunction

    function automatic bit on_cell(int v);
        return ((v / FRAC) % CELLPX) == 0;
    endfunction

    task automatic model_reset();
        m_x = INIT_X * FRAC; m_y = INIT_Y * FRAC;
        m_spd = YSPD0; m_wob = 0; m_cells = 0; m_mode = M_REST;
        m_latch = 0; m_side = 0; m_blk = 0;
    endtask

    task automatic model_clock();
        bit pz, sd;
        m_blk = 0;
        if (bus.respawn) begin
            model_reset();
        end else if (bus.startOfFrame) begin
            pz = m_latch || bus.push_req;
            sd = bus.push_req ? bus.push_side : m_side;
            m_latch = 0;
            case (m_mode)
                M_REST: begin
                    if (pz && !sd) begin
                        if (m_x / FRAC >= MAXX) m_blk = 1;
                        else begin
                            m_x = m_up(m_x, XSPD);
                            m_mode = on_cell(m_x) ? M_REST : M_RIGHT;
                        end
                    end else if (pz && sd) begin
                        if (m_x / FRAC <= MINX) m_blk = 1;
                        else begin
                            m_x = m_down(m_x, XSPD);
                            m_mode = on_cell(m_x) ? M_REST : M_LEFT;
                        end
                    end else if (bus.can_fall) begin
                        m_mode = M_WOB; m_wob = 0;
                    end
                end
                M_RIGHT: begin
                    m_x = m_up(m_x, XSPD);
                    if (on_cell(m_x)) m_mode = M_REST;
                end
                M_LEFT: begin
                    m_x = m_down(m_x, XSPD);
                    if (on_cell(m_x)) m_mode = M_REST;
                end
                M_WOB: begin
                    if (!bus.can_fall) m_mode = M_REST;
                    else begin
                        m_wob++;
                        if (m_wob == WOBN - 1) begin
                            m_mode = M_FALL; m_spd = YSPD0; m_cells = 0;
                        end
                    end
                end
                M_FALL: begin
                    m_y = m_up(m_y, m_spd);
                    m_spd = (m_spd + YACC > YMAX) ? YMAX : m_spd + YACC;
                    if (on_cell(m_y)) begin
                        if (m_cells < 15) m_cells++;
                        if (!bus.can_fall) m_mode = (m_cells >= CRASHN) ? M_CRASH : M_REST;
                    end
                end
                M_CRASH: if (bus.been_eaten) m_mode = M_GONE;
                default: ;
            endcase
        end else if (bus.push_req) begin
            m_latch = 1; m_side = bus.push_side;
        end
    endtask

    function automatic logic [27:0] pack_exp();
        logic [1:0] gs, img;
        logic       bsy;
        int         ph;
        gs  = (m_mode == M_FALL) ? 2'd1 : (m_mode == M_CRASH) ? 2'd2 :
              (m_mode == M_GONE) ? 2'd3 : 2'd0;
        ph  = (m_wob / 16) % 4;
        img = (m_mode == M_CRASH) ? 2'd3 :
              (m_mode == M_WOB && ph == 1) ? 2'd1 :
              (m_mode == M_WOB && ph == 3) ? 2'd2 : 2'd0;
        bsy = (m_mode == M_RIGHT || m_mode == M_LEFT || m_mode == M_WOB || m_mode == M_FALL);
        return {11'(m_x / FRAC), 11'(m_y / FRAC), gs, img, m_blk, bsy};
    endfunction

    task automatic check_outputs();
        logic [27:0] e;
        logic [10:0] ox, oy;
        e  = exp_q.pop_front();
        ox = bus.topLeftX;
        oy = bus.topLeftY;
        chk("topLeftX",     {21'd0, ox},               {21'd0, e[27:17]});
        chk("topLeftY",     {21'd0, oy},               {21'd0, e[16:6]});
        chk("gold_state",   {30'd0, bus.gold_state},   {30'd0, e[5:4]});
        chk("image",        {30'd0, bus.image},        {30'd0, e[3:2]});
        chk("push_blocked", {31'd0, bus.push_blocked}, {31'd0, e[1]});
        chk("busy",         {31'd0, bus.busy},         {31'd0, e[0]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_clock();
        exp_q.push_back(pack_exp());
        #1;
        check_outputs();
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic do_respawn();
        bus.respawn = 1'b1;
        tick();
        bus.respawn = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        resetN = 1'b1;
        exp_q.push_back(pack_exp());
        check_outputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        bus.startOfFrame = 1'b0;
        bus.respawn      = 1'b0;
        bus.push_req     = 1'b0;
        bus.push_side    = 1'b0;
        bus.can_fall     = 1'b0;
        bus.been_eaten   = 1'b0;
        do_reset();

        // idle frames
        frames(5);
        chk("idle_x", 32'(bus.topLeftX), 32);
        chk("idle_y", 32'(bus.topLeftY), 160);
        chk("idle_busy", {31'd0, bus.busy}, 0);

        // left push at MIN_X is refused with a single-clock pulse
        bus.push_req = 1'b1; bus.push_side = 1'b1;
        tick();
        bus.push_req = 1'b0;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        chk("blocked_pulse", {31'd0, bus.push_blocked}, 1);
        tick();
        chk("blocked_drop", {31'd0, bus.push_blocked}, 0);
        chk("blocked_x", 32'(bus.topLeftX), 32);

        // right push: 2 px per frame for one cell, held request does not retrigger
        bus.push_req = 1'b1; bus.push_side = 1'b0;
        tick();
        frame();
        chk("push_f1_x", 32'(bus.topLeftX), 34);
        chk("push_f1_busy", {31'd0, bus.busy}, 1);
        frames(14);
        bus.push_req = 1'b0;
        frame();
        chk("push_f16_x", 32'(bus.topLeftX), 64);
        chk("push_f16_busy", {31'd0, bus.busy}, 0);
        frames(2);
        chk("push_hold_x", 32'(bus.topLeftX), 64);

        // wobble, fall two cells, crash, collect
        do_respawn();
        bus.can_fall = 1'b1;
        frames(17);
        chk("wob_img_tilt_l", {30'd0, bus.image}, 1);
        frames(32);
        chk("wob_img_tilt_r", {30'd0, bus.image}, 2);
        frames(41);
        chk("fall_start_gs", {30'd0, bus.gold_state}, 1);
        chk("fall_start_y", 32'(bus.topLeftY), 160);
        frame();
        chk("fall_first_y", 32'(bus.topLeftY), 162);
        guard = 0;
        while (m_y / FRAC <= 192 && guard < 100) begin frame(); guard++; end
        bus.can_fall = 1'b0;
        guard = 0;
        while (m_mode == M_FALL && guard < 100) begin frame(); guard++; end
        chk("crash_y", 32'(bus.topLeftY), 224);
        chk("crash_gs", {30'd0, bus.gold_state}, 2);
        chk("crash_img", {30'd0, bus.image}, 3);
        bus.been_eaten = 1'b1;
        frame();
        bus.been_eaten = 1'b0;
        chk("collected_gs", {30'd0, bus.gold_state}, 3);

        // wobble abandoned part way through
        do_respawn();
        bus.can_fall = 1'b1;
        frames(40);
        bus.can_fall = 1'b0;
        frame();
        chk("abort_gs", {30'd0, bus.gold_state}, 0);
        chk("abort_img", {30'd0, bus.image}, 0);
        chk("abort_y", 32'(bus.topLeftY), 160);

        // single-cell fall lands safely
        do_respawn();
        bus.can_fall = 1'b1;
        frames(91);
        bus.can_fall = 1'b0;
        guard = 0;
        while (m_mode == M_FALL && guard < 100) begin frame(); guard++; end
        chk("one_cell_gs", {30'd0, bus.gold_state}, 0);
        chk("one_cell_y", 32'(bus.topLeftY), 192);

        // respawn coincident with a frame strobe mid-fall
        do_respawn();
        bus.can_fall = 1'b1;
        frames(95);
        bus.respawn = 1'b1; bus.startOfFrame = 1'b1;
        tick();
        bus.respawn = 1'b0; bus.startOfFrame = 1'b0;
        chk("respawn_x", 32'(bus.topLeftX), 32);
        chk("respawn_y", 32'(bus.topLeftY), 160);
        chk("respawn_gs", {30'd0, bus.gold_state}, 0);

        // randomized frames
        for (int cyc = 0; cyc < 15000; cyc++) begin
            bus.startOfFrame = (cyc % 3 == 0);
            bus.push_req     = ($urandom_range(0, 39) == 0);
            bus.push_side    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) bus.can_fall = ~bus.can_fall;
            bus.been_eaten   = ($urandom_range(0, 9) == 0);
            bus.respawn      = ($urandom_range(0, 2999) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
